// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite ROM arbitration slice.
package sprite_pkg;

  localparam int SPRITE_ADDR_W  = 10;
  localparam int SPRITE_DATA_W  = 4;
  localparam int NUM_SPRITE_REQ = 4;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_TANK1  = 2'd0;
  localparam req_id_t REQ_TANK2  = 2'd1;
  localparam req_id_t REQ_BULLET = 2'd2;
  localparam req_id_t REQ_HUD    = 2'd3;

  // Saturating increment for the per-frame grant counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with optional fixed priority for requester 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int PRIO0   = 0
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_valid,
  output logic               o_prio_hit
);

  localparam logic [ID_W:0] N_L = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0] w_idx;

  // Search upward from the pointer with wrap; requester 0 short-circuits when PRIO0 is set.
  always_comb begin
    o_gnt      = '0;
    o_winner   = '0;
    o_valid    = 1'b0;
    o_prio_hit = 1'b0;
    w_idx      = '0;
    if ((PRIO0 != 0) && i_req[0]) begin
      o_valid    = 1'b1;
      o_prio_hit = 1'b1;
      o_winner   = '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = {1'b0, i_ptr} + (ID_W+1)'(k);
        if (w_idx >= N_L) begin
          w_idx = w_idx - N_L;
        end else begin
          w_idx = w_idx;
        end
        if (!o_valid && i_req[w_idx[ID_W-1:0]]) begin
          o_valid  = 1'b1;
          o_winner = w_idx[ID_W-1:0];
        end else begin
          o_valid  = o_valid;
        end
      end
    end
    if (o_valid) begin
      o_gnt[o_winner] = 1'b1;
    end else begin
      o_gnt = '0;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one 1-cycle-latency sprite ROM between pixel-fetch requesters and
// returns each word tagged with its requester id three cycles after the grant.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = NUM_SPRITE_REQ,
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int DATA_W  = SPRITE_DATA_W,
  parameter int PRIO0   = 0
) (
  input  logic                         vga_clk,
  input  logic                         reset_n,
  input  logic                         frame_start,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [ADDR_W-1:0]            rom_address,
  input  logic [DATA_W-1:0]            rom_q,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [15:0]                  grant_count
);

  localparam int              ID_W    = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_winner;
  logic               w_valid;
  logic               w_prio_hit;

  logic [ID_W-1:0]    r_ptr;
  logic               r_s1_valid;
  logic [ID_W-1:0]    r_s1_id;
  logic               r_s2_valid;
  logic [ID_W-1:0]    r_s2_id;
  logic [15:0]        r_grant_count;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .PRIO0   (PRIO0)
  ) u_rr_arbiter (
    .i_req      (req),
    .i_ptr      (r_ptr),
    .o_gnt      (w_gnt),
    .o_winner   (w_winner),
    .o_valid    (w_valid),
    .o_prio_hit (w_prio_hit)
  );

  // Grant is combinational but forced low while reset is held.
  always_comb begin
    if (reset_n) begin
      gnt = w_gnt;
    end else begin
      gnt = '0;
    end
  end

  // Round-robin pointer: cleared by frame_start, untouched by a fixed-priority win.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (frame_start) begin
      r_ptr <= '0;
    end else if (w_valid && !w_prio_hit) begin
      r_ptr <= (w_winner == LAST_ID) ? '0 : w_winner + ID_W'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Address stage plus the two id/valid stages that track the ROM read.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_id     <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_id     <= '0;
    end else begin
      if (w_valid) begin
        rom_address <= req_addr[w_winner*ADDR_W +: ADDR_W];
        r_s1_id     <= w_winner;
      end else begin
        rom_address <= rom_address;
        r_s1_id     <= r_s1_id;
      end
      r_s1_valid <= w_valid;
      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;
    end
  end

  // Response stage: id and data only update on a valid beat so they hold when idle.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= r_s2_valid;
      if (r_s2_valid) begin
        rsp_id   <= r_s2_id;
        rsp_data <= rom_q;
      end else begin
        rsp_id   <= rsp_id;
        rsp_data <= rsp_data;
      end
    end
  end

  // Per-frame grant counter; a grant in the frame_start cycle is the first of the new frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant_count <= 16'd0;
    end else if (frame_start) begin
      r_grant_count <= w_valid ? 16'd1 : 16'd0;
    end else if (w_valid) begin
      r_grant_count <= sat_inc16(r_grant_count);
    end else begin
      r_grant_count <= r_grant_count;
    end
  end

  assign grant_count = r_grant_count;

endmodule
